reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin arbiter that shares one enabled data register among N requesters. Each requester presents a write request and data. The arbiter grants one requester at a time and drives the register's enable/data pair so that exactly one write lands per grant. It sits in front of the enabled-register storage used across the sequential designs, replacing ad-hoc enable muxing when several producers target one register.

## Interface
Parameters:
- N, 4, number of requesters (2..16)
- W, 8, register data width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled only on rising clk
- req  in  N  per-requester write request, held until granted
- wdata  in  N*W  requester i data in bits [i*W +: W]
- lock  in  N  per-requester burst hold (present only with macro, see Configuration)
- grant  out  N  one-hot grant; all-zero when idle
- owner  out  $clog2(N)  index of the last granted requester
- q  out  W  shared register contents
- busy  out  1  high while in GRANT state

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is high, select a winner by round-robin.
  - The search starts at index ptr and wraps through N-1 to 0; the first asserted req wins.
  - Register the one-hot grant, load owner with the winner, go to GRANT.
  - If no req bit is high, stay in IDLE with grant=0.
- GRANT:
  - Register write enable = 1; write data = wdata slice of owner.
  - q captures that data at the edge ending the GRANT cycle.
  - ptr becomes (owner+1) mod N.
  - Next state is IDLE and grant clears.
- Requester handshake: hold req and wdata stable until grant is seen. Deassert req in the cycle after grant, or keep it high to queue another write.
- A requester that keeps req high is rotated behind the other active requesters.
- Changes to req during GRANT do not affect the current transaction.
- The register holds its value whenever the state is not GRANT.
- Reset values: state IDLE, grant 0, owner 0, ptr 0, q 0, busy 0.
- Reset asserted during GRANT: no write happens, and all registers take their reset values at that edge.

## Timing
- req first seen high in cycle t (IDLE) -> grant high in cycle t+1 -> q updated and visible in cycle t+2.
- Maximum throughput without lock: one write every 2 cycles.
- Fairness: with all N requesters continuously active, each is granted exactly once per 2N cycles.
- grant and busy are registered outputs, with no combinational path from req.

## Configuration
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - The lock port exists.
  - In GRANT, if lock[owner] and req[owner] are both high, stay in GRANT, keep grant, and write wdata[owner] again on the next edge. This gives one write per cycle.
  - ptr does not advance while locked.
  - The lock is released on the first cycle where either signal is low; normal GRANT exit follows.
- Undefined: the lock port is absent and GRANT always exits after one cycle.

## Structure
- Package rr_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT)
  - the default N and W constants
  - a function computing the round-robin winner from req and ptr
- Sub-module wr_en_reg: W-bit register with synchronous reset and enable. It holds q, driven by the arbiter's enable and the selected data.

## Test plan
- Reset: assert reset 2 cycles with random req -> grant=0, q=0, owner=0, busy=0.
- Single requester: req=4'b0100, wdata[2]=8'hA5 at t -> grant=4'b0100 at t+1, q=8'hA5 at t+2, owner=2.
- All requesting continuously, distinct data per index -> grant sequence 0,1,2,3,0… with one idle cycle between each grant; each q value matches the granted index.
- Wrap-around: last owner=3, req=4'b1001 -> next grant is index 0, not 3.
- Reset mid-GRANT: assert reset in the cycle grant=4'b0010 with wdata[1]=8'h3C -> q stays 0 and grant clears at that edge.
- RR_ARB_LOCK_EN: req[1] and lock[1] held high for 4 cycles after grant, data 1,2,3,4 -> grant stays at 4'b0010 and q updates every cycle. Other requests wait until the lock drops, then go to index 2 onward.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types, default sizes and the round-robin winner search for reg_write_arbiter.
package rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_W     = 8;
  localparam int unsigned N_MAX     = 16;
  localparam int unsigned IDX_MAX_W = 4;

  // First asserted request at or after ptr, wrapping modulo n; 0 when nothing is requested.
  function automatic logic [IDX_MAX_W-1:0] rr_winner(input logic [N_MAX-1:0]     req,
                                                     input logic [IDX_MAX_W-1:0] ptr,
                                                     input int unsigned          n);
    logic [IDX_MAX_W-1:0] win;
    logic                 found;
    int unsigned          idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_MAX; i++) begin
      idx = (32'(ptr) + i) % n;
      if (!found && (i < n) && req[idx[IDX_MAX_W-1:0]]) begin
        win   = idx[IDX_MAX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wr_en_reg.sv
// W-bit storage register with synchronous active-high reset and write enable.
module wr_en_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of N requesters a single write into a shared register.
// Optional burst hold via lock[] is compiled in with RR_ARB_LOCK_EN.
module reg_write_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
`ifdef RR_ARB_LOCK_EN
  input  logic [N-1:0]         lock,
`endif
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic [W-1:0]         q,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(N);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [W-1:0]  slot [N];
  logic          wr_en;
  logic          hold;

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign slot[i] = wdata[i*W +: W];
  end

  assign win   = IW'(rr_winner(N_MAX'(req), IDX_MAX_W'(ptr), N));
  assign wr_en = (state == GRANT);

`ifdef RR_ARB_LOCK_EN
  assign hold = lock[owner] & req[owner];
`else
  assign hold = 1'b0;
`endif

  // Two-state grant sequencer; grant/owner/busy are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= N'(1) << win;
            owner <= win;
            busy  <= 1'b1;
            state <= GRANT;
          end else begin
            grant <= '0;
          end
        end
        GRANT: begin
          if (!hold) begin
            ptr   <= (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  wr_en_reg #(.W(W)) u_reg (
    .clk   (clk),
    .reset (reset),
    .en    (wr_en),
    .d     (slot[owner]),
    .q     (q)
  );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (N=4, W=8); lock scenario only with RR_ARB_LOCK_EN.
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
`ifdef RR_ARB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        busy;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  reg_write_arbiter #(.N(4), .W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
`ifdef RR_ARB_LOCK_EN
    .lock  (lock),
`endif
    .grant (grant),
    .owner (owner),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    wdata[i*8 +: 8] = d;
  endtask

  task automatic pulse_reset();
    req   = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'($urandom);
    tick();
    tick();
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    req   = '0;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    set_data(2, 8'hA5);
    req = 4'b0100;
    exp_q.push_back('{idx: 2'd2, data: 8'hA5});
    tick();
    e = exp_q.pop_front();
    checks++; if (grant !== (4'b0001 << e.idx)) begin errors++; $display("FAIL single_grant got %b exp %b", grant, 4'b0001 << e.idx); end
    checks++; if (owner !== e.idx) begin errors++; $display("FAIL single_owner got %0d exp %0d", owner, e.idx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    req = '0;
    tick();
    checks++; if (q !== e.data) begin errors++; $display("FAIL single_q got %h exp %h", q, e.data); end
    checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release got grant=%b busy=%b exp 0000/0", grant, busy); end
    set_data(2, 8'h11);
    tick();
    checks++; if (q !== e.data) begin errors++; $display("FAIL single_hold got %h exp %h", q, e.data); end
  endtask

  task automatic test_all_continuous();
    exp_t       e;
    int         cnt [4];
    logic [7:0] last;
    last = '0;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      set_data(i, 8'(8'h10 + i));
      cnt[i] = 0;
    end
    for (int k = 0; k < 8; k++) exp_q.push_back('{idx: 2'(k % 4), data: 8'(8'h10 + (k % 4))});
    req = 4'hF;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c % 2 == 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL all_scoreboard_empty at cycle %0d", c);
        end else begin
          e = exp_q.pop_front();
          checks++; if (grant !== (4'b0001 << e.idx)) begin errors++; $display("FAIL all_grant cycle %0d got %b exp %b", c, grant, 4'b0001 << e.idx); end
          checks++; if (owner !== e.idx) begin errors++; $display("FAIL all_owner cycle %0d got %0d exp %0d", c, owner, e.idx); end
          cnt[e.idx]++;
          last = e.data;
        end
      end else begin
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL all_idle cycle %0d got %b exp 0000", c, grant); end
        checks++; if (q !== last) begin errors++; $display("FAIL all_q cycle %0d got %h exp %h", c, q, last); end
      end
    end
    req = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (cnt[i] != 2) begin errors++; $display("FAIL all_fair idx %0d got %0d exp 2", i, cnt[i]); end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    set_data(3, 8'h77);
    req = 4'b1000;
    exp_q.push_back('{idx: 2'd3, data: 8'h77});
    tick();
    e = exp_q.pop_front();
    checks++; if (owner !== e.idx) begin errors++; $display("FAIL wrap_setup_owner got %0d exp %0d", owner, e.idx); end
    req = '0;
    tick();
    checks++; if (q !== e.data) begin errors++; $display("FAIL wrap_setup_q got %h exp %h", q, e.data); end
    set_data(0, 8'h5A);
    set_data(3, 8'hC3);
    req = 4'b1001;
    exp_q.push_back('{idx: 2'd0, data: 8'h5A});
    exp_q.push_back('{idx: 2'd3, data: 8'hC3});
    tick();
    e = exp_q.pop_front();
    checks++; if (grant !== (4'b0001 << e.idx)) begin errors++; $display("FAIL wrap_grant got %b exp %b", grant, 4'b0001 << e.idx); end
    req = 4'b1000;
    tick();
    checks++; if (q !== e.data) begin errors++; $display("FAIL wrap_q got %h exp %h", q, e.data); end
    tick();
    e = exp_q.pop_front();
    checks++; if (grant !== (4'b0001 << e.idx) || owner !== e.idx) begin errors++; $display("FAIL wrap_second got %b/%0d exp %b/%0d", grant, owner, 4'b0001 << e.idx, e.idx); end
    req = '0;
    tick();
    checks++; if (q !== e.data) begin errors++; $display("FAIL wrap_second_q got %h exp %h", q, e.data); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      set_data(0, 8'(8'hE0 + k));
      exp_q.push_back('{idx: 2'd0, data: 8'(8'hE0 + k)});
      tick();
      e = exp_q.pop_front();
      checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL b2b_grant %0d got %b/%b exp 0001/1", k, grant, busy); end
      tick();
      checks++; if (q !== e.data || grant !== 4'b0) begin errors++; $display("FAIL b2b_q %0d got %h/%b exp %h/0000", k, q, grant, e.data); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    pulse_reset();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_pre_q got %h exp 00", q); end
    set_data(1, 8'h3C);
    req = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mid_grant got %b exp 0010", grant); end
    reset = 1'b1;
    tick();
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL mid_grant_clear got %b exp 0000", grant); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_q got %h exp 00", q); end
    checks++; if (busy !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL mid_state got busy=%b owner=%0d exp 0/0", busy, owner); end
    reset = 1'b0;
    req   = '0;
    tick();
    checks++; if (q !== 8'h00 || grant !== 4'b0) begin errors++; $display("FAIL mid_after got %h/%b exp 00/0000", q, grant); end
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    pulse_reset();
    lock = 4'b0010;
    set_data(1, 8'd1);
    set_data(2, 8'h99);
    req = 4'b0110;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL lock_grant got %b exp 0010", grant); end
    for (int k = 1; k <= 4; k++) begin
      set_data(1, 8'(k));
      if (k == 4) lock = '0;
      tick();
      checks++; if (q !== 8'(k)) begin errors++; $display("FAIL lock_q %0d got %h exp %h", k, q, 8'(k)); end
      if (k < 4) begin
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL lock_hold %0d got %b exp 0010", k, grant); end
      end else begin
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL lock_exit got %b exp 0000", grant); end
      end
    end
    req = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL lock_next got %b exp 0100", grant); end
    req = '0;
    tick();
    checks++; if (q !== 8'h99) begin errors++; $display("FAIL lock_next_q got %h exp 99", q); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    req   = '0;
    wdata = '0;
`ifdef RR_ARB_LOCK_EN
    lock  = '0;
`endif
    test_reset();
    test_single();
    test_all_continuous();
    test_wrap();
    test_back_to_back();
    test_reset_mid_grant();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
